msx_audio_mixer: RTL and testbench

- Parametrised N-channel audio mixer; successor to the fixed PSG/OPLL/PCM sum and clip table at emu top level.
- Per-channel format select (signed or offset-binary), gain, and L/R routing.
- Time-multiplexed multiply-accumulate, one channel per clock, then saturation to the output width.
- Sits between emsx_top audio outputs and AUDIO_L/AUDIO_R. Produces a one-cycle valid pulse per mixed sample.

---
 rtl/msx_mix_pkg.sv | 41 ++++
 rtl/msx_mix_dcblock.sv | 45 ++++
 rtl/msx_audio_mixer.sv | 199 +++++++++++++++++++
 tb/tb_msx_audio_mixer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_mix_pkg.sv
// Shared types and helpers for the msx_audio_mixer slice: pass FSM states,
// gain scaling constant and a generic signed saturation helper.
package msx_mix_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    SAT   = 3'd2,
    FILT  = 3'd3,
    OUT   = 3'd4
  } mix_state_t;

  // Gain is fixed-point with three fractional bits (8 = unity).
  localparam int GAIN_SHIFT = 3;
  localparam int SAT_W      = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    clip;
  } sat_t;

  function automatic sat_t sat_to_width(input logic signed [SAT_W-1:0] value,
                                        input int width);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_t res;
    max_v     = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v     = -max_v - 64'sd1;
    res.value = value;
    res.clip  = 1'b0;
    if (value > max_v) begin
      res.value = max_v;
      res.clip  = 1'b1;
    end else if (value < min_v) begin
      res.value = min_v;
      res.clip  = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/msx_mix_dcblock.sv
// One side of the optional DC-blocking high-pass filter; history advances only
// when en is high (once per completed mix pass).
module msx_mix_dcblock
  import msx_mix_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int DC_K  = 8
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic signed [OUT_W-1:0] x,
  output logic signed [OUT_W-1:0] y,
  output logic                    clip
);

  localparam int INT_W = OUT_W + DC_K;

  logic signed [OUT_W-1:0] x_prev;
  logic signed [INT_W-1:0] y_prev;
  logic signed [INT_W-1:0] y_full;
  sat_t                    y_sat;
  logic                    unused_hi;

  always_comb begin
    y_full = INT_W'(x) - INT_W'(x_prev) + y_prev - (y_prev >>> DC_K);
    y_sat  = sat_to_width(SAT_W'(y_full), OUT_W);
    y      = y_sat.value[OUT_W-1:0];
    clip   = y_sat.clip;
  end

  assign unused_hi = ^y_sat.value[SAT_W-1:OUT_W];

  // History stores the saturated output so the recursion stays bounded.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      x_prev <= '0;
      y_prev <= '0;
    end else if (en) begin
      x_prev <= x;
      y_prev <= INT_W'(y);
    end
  end

endmodule

// File: rtl/msx_audio_mixer.sv
// N-channel time-multiplexed audio mixer with per-channel format, gain and L/R
// routing. Optional DC-block filter stage enabled by MIX_DC_FILTER_EN.
module msx_audio_mixer
  import msx_mix_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CH_W   = 16,
  parameter int GAIN_W = 5,
  parameter int OUT_W  = 16,
  parameter int DC_K   = 8
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    sample_stb,
  input  logic [NCH*CH_W-1:0]     ch_data,
  input  logic [NCH-1:0]          ch_signed,
  input  logic [NCH*GAIN_W-1:0]   ch_gain,
  input  logic [NCH*2-1:0]        ch_route,
  input  logic                    clip_clr,
  output logic [OUT_W-1:0]        audio_l,
  output logic [OUT_W-1:0]        audio_r,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    clip_l,
  output logic                    clip_r,
  output logic                    overrun,
  output logic [2:0]              dbg_state
);

  // Handshake: sample_stb is accepted only in a cycle where busy is low;
  // out_valid is a single-cycle pulse with no backpressure, and audio_l/r hold
  // until the next pulse.

  localparam int P_W   = CH_W + GAIN_W + 1;
  localparam int ACC_W = P_W + $clog2(NCH);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  mix_state_t state, state_nxt;

  logic [IDX_W-1:0]        idx;
  logic [NCH*CH_W-1:0]     data_q;
  logic [NCH-1:0]          sig_q;
  logic [NCH*GAIN_W-1:0]   gain_q;
  logic [NCH*2-1:0]        route_q;
  logic signed [ACC_W-1:0] acc_l, acc_r;

  logic [CH_W-1:0]         cur_data;
  logic [CH_W-1:0]         x_conv;
  logic [GAIN_W-1:0]       cur_gain;
  logic                    cur_to_l, cur_to_r;
  logic signed [P_W-1:0]   x_ext, g_ext, prod;
  logic signed [ACC_W-1:0] sh_l, sh_r;
  sat_t                    sat_l, sat_r;
  logic [OUT_W-1:0]        res_l, res_r;
  logic                    load_out;
  logic                    clip_ev_l, clip_ev_r;
  logic                    filt_clip_l, filt_clip_r;
  logic                    ov_set;
  logic                    unused_sat;

  // Per-channel operand select and multiply for the channel under idx.
  always_comb begin
    cur_data = data_q[int'(idx)*CH_W +: CH_W];
    cur_gain = gain_q[int'(idx)*GAIN_W +: GAIN_W];
    cur_to_l = route_q[2*int'(idx)+1];
    cur_to_r = route_q[2*int'(idx)];
    x_conv   = sig_q[idx] ? cur_data : {~cur_data[CH_W-1], cur_data[CH_W-2:0]};
    x_ext    = P_W'($signed(x_conv));
    g_ext    = P_W'(cur_gain);
    prod     = x_ext * g_ext;
  end

  always_comb begin
    sh_l  = acc_l >>> GAIN_SHIFT;
    sh_r  = acc_r >>> GAIN_SHIFT;
    sat_l = sat_to_width(SAT_W'(sh_l), OUT_W);
    sat_r = sat_to_width(SAT_W'(sh_r), OUT_W);
  end

  assign unused_sat = ^{sat_l.value[SAT_W-1:OUT_W], sat_r.value[SAT_W-1:OUT_W]};

`ifdef MIX_DC_FILTER_EN
  logic signed [OUT_W-1:0] sat_q_l, sat_q_r, y_l, y_r;
  logic                    fclip_l, fclip_r;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sat_q_l <= '0;
      sat_q_r <= '0;
    end else if (state == SAT) begin
      sat_q_l <= sat_l.value[OUT_W-1:0];
      sat_q_r <= sat_r.value[OUT_W-1:0];
    end
  end

  msx_mix_dcblock #(.OUT_W(OUT_W), .DC_K(DC_K)) u_dc_l (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .en      (state == FILT),
    .x       (sat_q_l),
    .y       (y_l),
    .clip    (fclip_l)
  );

  msx_mix_dcblock #(.OUT_W(OUT_W), .DC_K(DC_K)) u_dc_r (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .en      (state == FILT),
    .x       (sat_q_r),
    .y       (y_r),
    .clip    (fclip_r)
  );

  assign load_out    = (state == FILT);
  assign res_l       = y_l;
  assign res_r       = y_r;
  assign filt_clip_l = (state == FILT) && fclip_l;
  assign filt_clip_r = (state == FILT) && fclip_r;
`else
  logic unused_dc_k;

  assign unused_dc_k = (DC_K > 0);
  assign load_out    = (state == SAT);
  assign res_l       = sat_l.value[OUT_W-1:0];
  assign res_r       = sat_r.value[OUT_W-1:0];
  assign filt_clip_l = 1'b0;
  assign filt_clip_r = 1'b0;
`endif

  assign clip_ev_l = ((state == SAT) && sat_l.clip) || filt_clip_l;
  assign clip_ev_r = ((state == SAT) && sat_r.clip) || filt_clip_r;
  assign ov_set    = sample_stb && (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sample_stb) state_nxt = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_nxt = SAT;
`ifdef MIX_DC_FILTER_EN
      SAT:     state_nxt = FILT;
`else
      SAT:     state_nxt = OUT;
`endif
      FILT:    state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= '0;
      data_q  <= '0;
      sig_q   <= '0;
      gain_q  <= '0;
      route_q <= '0;
      acc_l   <= '0;
      acc_r   <= '0;
      audio_l <= '0;
      audio_r <= '0;
      clip_l  <= 1'b0;
      clip_r  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (state == IDLE && sample_stb) begin
        data_q  <= ch_data;
        sig_q   <= ch_signed;
        gain_q  <= ch_gain;
        route_q <= ch_route;
        acc_l   <= '0;
        acc_r   <= '0;
        idx     <= '0;
      end else if (state == ACCUM) begin
        if (cur_to_l) acc_l <= acc_l + ACC_W'(prod);
        if (cur_to_r) acc_r <= acc_r + ACC_W'(prod);
        idx <= idx + 1'b1;
      end
      if (load_out) begin
        audio_l <= res_l;
        audio_r <= res_r;
      end
      // Sticky flags: a new event in the same cycle as clip_clr wins.
      clip_l  <= clip_ev_l || (clip_l && !clip_clr);
      clip_r  <= clip_ev_r || (clip_r && !clip_clr);
      overrun <= ov_set || (overrun && !clip_clr);
    end
  end

  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_msx_audio_mixer.sv
// Self-checking bench for msx_audio_mixer: behavioural pass model with an
// expected-result queue, per-cycle compare, directed and randomized stimulus.
module tb_msx_audio_mixer;

  localparam int NCH    = 4;
  localparam int CH_W   = 16;
  localparam int GAIN_W = 5;
  localparam int OUT_W  = 16;
  localparam int LAT    = NCH + 2;

  logic                  clk_sys;
  logic                  reset_n;
  logic                  sample_stb;
  logic [NCH*CH_W-1:0]   ch_data;
  logic [NCH-1:0]        ch_signed;
  logic [NCH*GAIN_W-1:0] ch_gain;
  logic [NCH*2-1:0]      ch_route;
  logic                  clip_clr;
  logic [OUT_W-1:0]      audio_l, audio_r;
  logic                  out_valid, busy, clip_l, clip_r, overrun;
  logic [2:0]            dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  msx_audio_mixer #(.NCH(NCH), .CH_W(CH_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .DC_K(8)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .sample_stb (sample_stb),
    .ch_data    (ch_data),
    .ch_signed  (ch_signed),
    .ch_gain    (ch_gain),
    .ch_route   (ch_route),
    .clip_clr   (clip_clr),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .out_valid  (out_valid),
    .busy       (busy),
    .clip_l     (clip_l),
    .clip_r     (clip_r),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sum of signed channel values times gain/8, clamped.
  function automatic logic [OUT_W:0] clamp_out(input longint v);
    longint hi, lo;
    logic [63:0] t;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) begin
      t = hi;
      return {1'b1, t[OUT_W-1:0]};
    end
    if (v < lo) begin
      t = lo;
      return {1'b1, t[OUT_W-1:0]};
    end
    t = v;
    return {1'b0, t[OUT_W-1:0]};
  endfunction

  function automatic logic [2*OUT_W+1:0] model_mix(
      input logic [NCH*CH_W-1:0] d, input logic [NCH-1:0] s,
      input logic [NCH*GAIN_W-1:0] g, input logic [NCH*2-1:0] r);
    longint sl, sr, v, p;
    logic [CH_W-1:0] di;
    logic [OUT_W:0] cl, cr;
    sl = 0;
    sr = 0;
    for (int i = 0; i < NCH; i++) begin
      di = d[i*CH_W +: CH_W];
      if (s[i]) v = longint'($signed(di));
      else      v = longint'(di) - (longint'(1) <<< (CH_W - 1));
      p = v * longint'(g[i*GAIN_W +: GAIN_W]);
      if (r[2*i+1]) sl += p;
      if (r[2*i])   sr += p;
    end
    cl = clamp_out(sl >>> 3);
    cr = clamp_out(sr >>> 3);
    return {cl[OUT_W], cr[OUT_W], cl[OUT_W-1:0], cr[OUT_W-1:0]};
  endfunction

  // Scoreboard state
  logic [2*OUT_W+1:0] exp_q[$];
  int                 m_cnt = 0;
  logic [OUT_W-1:0]   m_l = '0, m_r = '0;
  logic               m_cl = 1'b0, m_cr = 1'b0, m_ov = 1'b0;

  always @(posedge clk_sys or negedge reset_n) begin : model
    logic cl_set, cr_set, ov_set;
    logic [2*OUT_W+1:0] e;
    if (!reset_n) begin
      m_cnt = 0;
      m_l = '0; m_r = '0;
      m_cl = 1'b0; m_cr = 1'b0; m_ov = 1'b0;
      exp_q.delete();
    end else begin
      cl_set = 1'b0; cr_set = 1'b0; ov_set = 1'b0;
      if (m_cnt == 0) begin
        if (sample_stb) begin
          exp_q.push_back(model_mix(ch_data, ch_signed, ch_gain, ch_route));
          m_cnt = 1;
        end
      end else begin
        if (sample_stb) ov_set = 1'b1;
        m_cnt++;
        if (m_cnt == LAT) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_l = e[2*OUT_W-1:OUT_W];
            m_r = e[OUT_W-1:0];
            cl_set = e[2*OUT_W+1];
            cr_set = e[2*OUT_W];
          end
        end else if (m_cnt > LAT) begin
          m_cnt = 0;
        end
      end
      if (clip_clr) begin
        m_cl = 1'b0; m_cr = 1'b0; m_ov = 1'b0;
      end
      if (cl_set) m_cl = 1'b1;
      if (cr_set) m_cr = 1'b1;
      if (ov_set) m_ov = 1'b1;
    end
  end

  // Per-cycle compare
  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("busy",      busy,      m_cnt != 0);
      check("out_valid", out_valid, m_cnt == LAT);
      check("audio_l",   audio_l,   m_l);
      check("audio_r",   audio_r,   m_r);
      check("clip_l",    clip_l,    m_cl);
      check("clip_r",    clip_r,    m_cr);
      check("overrun",   overrun,   m_ov);
    end
  end

  // Driver tasks
  task automatic clear_all();
    ch_data = '0; ch_signed = '0; ch_gain = '0; ch_route = '0;
  endtask

  task automatic set_ch(input int i, input logic [CH_W-1:0] d, input logic s,
                        input logic [GAIN_W-1:0] g, input logic [1:0] r);
    ch_data[i*CH_W +: CH_W]     = d;
    ch_signed[i]                = s;
    ch_gain[i*GAIN_W +: GAIN_W] = g;
    ch_route[2*i +: 2]          = r;
  endtask

  task automatic randomize_inputs();
    ch_data   = {$urandom, $urandom};
    ch_signed = NCH'($urandom);
    ch_route  = (NCH*2)'($urandom);
    if ($urandom_range(0, 1) == 0) ch_gain = (NCH*GAIN_W)'($urandom);
    else for (int i = 0; i < NCH; i++) ch_gain[i*GAIN_W +: GAIN_W] = GAIN_W'($urandom_range(0, 8));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk_sys);
      lat++;
    end while (out_valid !== 1'b1 && lat < 20);
  endtask

  task automatic do_pass(input string name);
    int lat;
    @(posedge clk_sys); #2; sample_stb = 1'b1;
    @(posedge clk_sys); #2; sample_stb = 1'b0;
    wait_valid(lat);
    check({name, "_latency"}, lat, LAT);
  endtask

  initial begin
    int seen_v, seen_b, lat;
    reset_n = 1'b0; sample_stb = 1'b0; clip_clr = 1'b0;
    clear_all();

    for (int i = 0; i < 4; i++) begin
      @(posedge clk_sys); #2;
      randomize_inputs();
      sample_stb = 1'($urandom_range(0, 1));
      clip_clr   = 1'($urandom_range(0, 1));
      chk_en     = 1'b1;
    end
    @(negedge clk_sys);
    check("rst_audio_l", audio_l, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);

    @(posedge clk_sys); #2;
    reset_n = 1'b1; sample_stb = 1'b0; clip_clr = 1'b0;
    seen_v = 0; seen_b = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (out_valid) seen_v = 1;
      if (busy) seen_b = 1;
    end
    check("idle_no_valid", seen_v, 0);
    check("idle_no_busy", seen_b, 0);

    clear_all(); set_ch(0, 16'h1000, 1'b1, 5'd8, 2'b11);
    do_pass("unity");
    check("unity_l", audio_l, 16'h1000);
    check("unity_r", audio_r, 16'h1000);

    clear_all(); set_ch(1, 16'h8000, 1'b0, 5'd8, 2'b11);
    do_pass("ob_mid");
    check("ob_mid_l", audio_l, 16'h0000);
    set_ch(1, 16'hFFFF, 1'b0, 5'd8, 2'b11);
    do_pass("ob_max");
    check("ob_max_l", audio_l, 16'h7FFF);
    set_ch(1, 16'h0000, 1'b0, 5'd8, 2'b11);
    do_pass("ob_min");
    check("ob_min_r", audio_r, 16'h8000);
    check("ob_min_noclip", clip_l, 0);

    clear_all();
    set_ch(0, 16'h7000, 1'b1, 5'd16, 2'b11);
    set_ch(1, 16'h7000, 1'b1, 5'd16, 2'b11);
    do_pass("sat_pos");
    check("sat_pos_l", audio_l, 16'h7FFF);
    check("sat_pos_clip_l", clip_l, 1);
    check("sat_pos_clip_r", clip_r, 1);
    set_ch(0, 16'h9000, 1'b1, 5'd16, 2'b11);
    set_ch(1, 16'h9000, 1'b1, 5'd16, 2'b11);
    do_pass("sat_neg");
    check("sat_neg_r", audio_r, 16'h8000);
    @(posedge clk_sys); #2; clip_clr = 1'b1;
    @(posedge clk_sys); #2; clip_clr = 1'b0;
    @(negedge clk_sys);
    check("clr_clip_l", clip_l, 0);
    check("clr_clip_r", clip_r, 0);

    clear_all();
    set_ch(0, 16'h0100, 1'b1, 5'd8, 2'b10);
    set_ch(2, 16'h0200, 1'b1, 5'd4, 2'b01);
    do_pass("route");
    check("route_l", audio_l, 16'h0100);
    check("route_r", audio_r, 16'h0100);

    clear_all(); set_ch(0, 16'h1000, 1'b1, 5'd8, 2'b11);
    @(posedge clk_sys); #2; sample_stb = 1'b1;
    @(posedge clk_sys); #2; sample_stb = 1'b0;
    @(posedge clk_sys); #2; sample_stb = 1'b1;
    set_ch(0, 16'h7FFF, 1'b1, 5'd31, 2'b11);
    @(posedge clk_sys); #2; sample_stb = 1'b0;
    wait_valid(lat);
    check("ovr_valid_seen", out_valid, 1);
    check("ovr_l", audio_l, 16'h1000);
    check("ovr_flag", overrun, 1);
    @(posedge clk_sys); #2; clip_clr = 1'b1;
    @(posedge clk_sys); #2; clip_clr = 1'b0;
    @(negedge clk_sys);
    check("ovr_cleared", overrun, 0);

    clear_all(); set_ch(0, 16'h2000, 1'b1, 5'd8, 2'b11);
    @(posedge clk_sys); #2; sample_stb = 1'b1;
    @(posedge clk_sys); #2; sample_stb = 1'b0;
    @(posedge clk_sys); #2; reset_n = 1'b0;
    @(negedge clk_sys);
    check("midrst_busy", busy, 0);
    check("midrst_audio_l", audio_l, 0);
    repeat (2) @(posedge clk_sys);
    #2; reset_n = 1'b1;
    seen_v = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (out_valid) seen_v = 1;
    end
    check("midrst_no_valid", seen_v, 0);

    for (int it = 0; it < 800; it++) begin
      @(posedge clk_sys); #2;
      randomize_inputs();
      sample_stb = ($urandom_range(0, 3) == 0);
      clip_clr   = ($urandom_range(0, 15) == 0);
      reset_n    = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk_sys); #2;
    reset_n = 1'b1; sample_stb = 1'b0; clip_clr = 1'b0;
    repeat (LAT + 4) @(posedge clk_sys);
    @(negedge clk_sys);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
